// File: rtl/uart_rx_fifo.sv
// Receive-side circular byte FIFO behind uart_receiver: edge-detected capture, show-ahead read,
// sticky overflow. Optional registered almost_full output with UART_RX_FIFO_ALMOST_FULL_EN.
module uart_rx_fifo #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8,
    parameter int AF_LEVEL   = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   rx_data,
    input  logic                    rx_ready,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    input  logic                    clear_overflow
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    ,
    output logic                    almost_full
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_rx_fifo: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  rx_ready_q;
    logic                  push_stb;
    logic                  do_push;
    logic                  do_pop;
    logic                  drop;
    logic [CNT_W-1:0]      count_next;

    // Handshake: a byte is captured on the rising edge of rx_ready (no back-pressure exists,
    // so a full FIFO drops it and flags overflow); rd_en with empty == 0 pops the head at the
    // clock edge, and rd_data always shows the current head while empty == 0.
    always_comb begin
        push_stb   = rx_ready & ~rx_ready_q;
        do_pop     = rd_en & ~empty;
        do_push    = push_stb & (~full | do_pop);
        drop       = push_stb & full & ~do_pop;
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_next = count - CNT_W'(1);
        end
    end

    assign rd_data = mem[rd_ptr];

    // Storage has no reset; occupancy tracking alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (reset && do_push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            overflow   <= 1'b0;
            rx_ready_q <= 1'b1;
        end else begin
            rx_ready_q <= rx_ready;
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == DEPTH_C);
            // A drop on the same edge as a clear leaves the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    generate
        if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af_level
            $error("uart_rx_fifo: AF_LEVEL must be within 1..DEPTH");
        end
    endgenerate

    localparam logic [CNT_W-1:0] AF_LEVEL_C = CNT_W'(AF_LEVEL);

    always_ff @(posedge clk) begin
        if (!reset) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (count_next >= AF_LEVEL_C);
        end
    end
`else
    localparam int unused_af_level = AF_LEVEL;
`endif

endmodule
